cook_timer_ctrl: RTL

COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

---
 rtl/cook_timer_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer: BCD mm:ss keypad entry, one-second countdown, door interlock.
// Optional feature macro: COOK_TIMER_QUICK_START_EN (start at 00:00 loads 00:30 and cooks).
//
// state | meaning
// IDLE  | time entry; keys shift in from the right, stop clears
// COOK  | magnetron on, prescaler running, time counts down
// PAUSE | door opened or stop pressed; time and prescaler frozen
// DONE  | countdown reached 00:00; any key, stop or door open returns to IDLE
module cook_timer_ctrl #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [1:0] state,
    output logic       mag_on,
    output logic       done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LP_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COOK  = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        r_state;
    logic [3:0]    r_min_tens;
    logic [3:0]    r_min_units;
    logic [3:0]    r_sec_tens;
    logic [3:0]    r_sec_units;
    logic [PW-1:0] r_presc;

    logic [3:0] w_dec_mt;
    logic [3:0] w_dec_mu;
    logic [3:0] w_dec_st;
    logic [3:0] w_dec_su;
    logic       w_time_zero;
    logic       w_last_sec;
    logic       w_key_ok;
    logic       w_tick;

    assign w_time_zero = (r_min_tens == 4'd0) && (r_min_units == 4'd0) &&
                         (r_sec_tens == 4'd0) && (r_sec_units == 4'd0);
    assign w_last_sec  = (r_min_tens == 4'd0) && (r_min_units == 4'd0) &&
                         (r_sec_tens == 4'd0) && (r_sec_units == 4'd1);
    assign w_key_ok    = key_valid && (key_digit <= 4'd9);
    assign w_tick      = (r_presc == LP_LAST);

    // Borrow chain; sec_tens above 5 simply counts down like any other digit.
    always_comb begin
        w_dec_mt = r_min_tens;
        w_dec_mu = r_min_units;
        w_dec_st = r_sec_tens;
        w_dec_su = r_sec_units;
        if (r_sec_units != 4'd0) begin
            w_dec_su = r_sec_units - 4'd1;
        end else if (r_sec_tens != 4'd0) begin
            w_dec_st = r_sec_tens - 4'd1;
            w_dec_su = 4'd9;
        end else if (r_min_units != 4'd0) begin
            w_dec_mu = r_min_units - 4'd1;
            w_dec_st = 4'd5;
            w_dec_su = 4'd9;
        end else begin
            w_dec_mt = r_min_tens - 4'd1;
            w_dec_mu = 4'd9;
            w_dec_st = 4'd5;
            w_dec_su = 4'd9;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_min_tens  <= 4'd0;
            r_min_units <= 4'd0;
            r_sec_tens  <= 4'd0;
            r_sec_units <= 4'd0;
            r_presc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (stop) begin
                        r_min_tens  <= 4'd0;
                        r_min_units <= 4'd0;
                        r_sec_tens  <= 4'd0;
                        r_sec_units <= 4'd0;
                    end else if (start) begin
                        if (door_closed && !w_time_zero) begin
                            r_state <= S_COOK;
                            r_presc <= '0;
                        end
`ifdef COOK_TIMER_QUICK_START_EN
                        else if (door_closed && w_time_zero) begin
                            r_state    <= S_COOK;
                            r_presc    <= '0;
                            r_sec_tens <= 4'd3;
                        end
`endif
                    end else if (w_key_ok) begin
                        r_min_tens  <= r_min_units;
                        r_min_units <= r_sec_tens;
                        r_sec_tens  <= r_sec_units;
                        r_sec_units <= key_digit;
                    end
                end
                S_COOK: begin
                    if (!door_closed || stop) begin
                        r_state <= S_PAUSE;
                    end else if (w_tick) begin
                        r_presc     <= '0;
                        r_min_tens  <= w_dec_mt;
                        r_min_units <= w_dec_mu;
                        r_sec_tens  <= w_dec_st;
                        r_sec_units <= w_dec_su;
                        if (w_last_sec) begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    // Prescaler is held so a resumed cook keeps its partial second.
                    if (stop) begin
                        r_state     <= S_IDLE;
                        r_min_tens  <= 4'd0;
                        r_min_units <= 4'd0;
                        r_sec_tens  <= 4'd0;
                        r_sec_units <= 4'd0;
                    end else if (start && door_closed) begin
                        r_state <= S_COOK;
                    end
                end
                S_DONE: begin
                    if (stop || key_valid || !door_closed) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign min_tens  = r_min_tens;
    assign min_units = r_min_units;
    assign sec_tens  = r_sec_tens;
    assign sec_units = r_sec_units;
    assign state     = r_state;
    assign mag_on    = (r_state == S_COOK);
    assign done      = (r_state == S_DONE);

endmodule
